// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector for a single-bit input stream. The pattern is
// PAT_W bits long and can be reprogrammed at runtime. Matches can overlap or
// be non-overlapping. The block produces:
//   - a Mealy match strobe,
//   - a registered copy of that strobe,
//   - a saturating match counter.
// Input bits are qualified by x_valid.
//
// Optional feature macro:
//   SEQDET_MASK_EN - adds the cfg_mask port and a mask register. A mask bit
//                    of 1 makes the matching pattern bit a don't-care.
//                    When the macro is undefined, matching is exact equality.
//
// Parameters:
//   PAT_W   pattern length in bits (2..16)
//   CNT_W   match counter width (1..32)
//   RST_PAT pattern loaded by reset
//   RST_OVL overlap mode loaded by reset
//
// Ports:
//   clk          in   rising-edge clock
//   aresetn      in   asynchronous active-low reset
//   x_valid      in   x carries a new stream bit this cycle
//   x            in   stream bit
//   cfg_load     in   capture cfg_pattern/cfg_overlap (and cfg_mask) this edge
//   cfg_pattern  in   new pattern; bit PAT_W-1 is received first, bit 0 last
//   cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//   cfg_mask     in   per-bit don't-care, 1 = ignore (SEQDET_MASK_EN only)
//   z            out  combinational match strobe, same cycle as the last bit
//   z_q          out  z registered one cycle
//   match_cnt    out  saturating count of matches since reset or last load
//   armed        out  history is full and the detector is comparing
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 3'b101,
    parameter logic             RST_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    // The fill counter only has to reach PAT_W-1.
    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_DETECT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_q_q, z_q_d;
    logic               armed_q, armed_d;
`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0]   mask_q, mask_d;
`endif

    logic [PAT_W-1:0]   cand;
    logic               hit;
    logic               accept;

    // The counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // A load cycle takes priority over the stream, so its bit is dropped.
    assign accept = x_valid & ~cfg_load;

    // The newest bit sits at bit 0. This lines up with the pattern, whose
    // bit 0 is received last.
    assign cand = {hist_q, x};

`ifdef SEQDET_MASK_EN
    assign hit = (((cand ^ pat_q) & ~mask_q) == '0);
`else
    assign hit = (cand == pat_q);
`endif

    assign z = accept & (state_q == ST_DETECT) & hit;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        z_q_d   = z;
`ifdef SEQDET_MASK_EN
        mask_d  = mask_q;
`endif

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
`ifdef SEQDET_MASK_EN
            mask_d  = cfg_mask;
`endif
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            state_d = ST_FILL;
        end else if (x_valid) begin
            case (state_q)
                ST_FILL: begin
                    hist_d = cand[PAT_W-2:0];
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_DETECT;
                    end
                end
                default: begin
                    if (z && !ovl_q) begin
                        // Non-overlapping: the next match must be built
                        // from PAT_W fresh bits.
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        hist_d = cand[PAT_W-2:0];
                    end
                end
            endcase
            if (z) begin
                cnt_d = sat_inc(cnt_q);
            end
        end

        armed_d = (state_d == ST_DETECT);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_FILL;
            pat_q   <= RST_PAT;
            ovl_q   <= RST_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            z_q_q   <= 1'b0;
            armed_q <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            z_q_q   <= z_q_d;
            armed_q <= armed_d;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign z_q       = z_q_q;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule
